pll_wrapper_ctrl: RTL and testbench

- Digital control wrapper around the system PLL.
- Sequences PLL lock and generates the 28 MHz and 7 MHz clock enables from the fast system clock.
- Performs runtime PLL reconfiguration (standard vs. "eightmhz" profile) by shifting a configuration scan chain.
- Sits between the analog PLL primitive and the Minimig/TG68K clock consumers; `locked` gates the CPU and the 7 MHz divider.

---
 rtl/pll_wrapper_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pll_wrapper_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_wrapper_ctrl.sv
// PLL control wrapper: lock sequencing, 28/7 MHz clock enables, scan-chain reconfiguration.
// Optional macro PLLW_RECONFIG_COUNT_EN adds a saturating reconfig_count output.
module pll_wrapper_ctrl #(
  parameter int LOCK_CYCLES = 64,
  parameter int CFG_BITS    = 16,
  parameter logic [CFG_BITS-1:0] PROFILE_STD = 16'hA5C3,
  parameter logic [CFG_BITS-1:0] PROFILE_8M  = 16'h3C5A
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       eightmhz,
  output logic       locked,
  output logic       ena28,
  output logic       ena7,
  output logic       scanclkena,
  output logic       scandata,
  output logic       configupdate,
  output logic       busy,
  output logic       mode
`ifdef PLLW_RECONFIG_COUNT_EN
  ,
  output logic [7:0] reconfig_count
`endif
);

  localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int BC_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_CYCLES - 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(CFG_BITS - 1);

  typedef enum logic [1:0] {
    ST_LOCKING = 2'd0,
    ST_RUN     = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_UPDATE  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [LC_W-1:0]     lock_cnt, lock_cnt_nxt;
  logic [BC_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [CFG_BITS-1:0] shreg, shreg_nxt;
  logic                locked_nxt;
  logic                busy_nxt;
  logic                mode_nxt;
  logic                target, target_nxt;
  logic                eightmhz_p0, eightmhz_s;
  logic                locked_p1;
  logic [3:0]          divider;

  // Input synchronizer for the asynchronous board switch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eightmhz_p0 <= 1'b0;
      eightmhz_s  <= 1'b0;
    end else begin
      eightmhz_p0 <= eightmhz;
      eightmhz_s  <= eightmhz_p0;
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_LOCKING;
      lock_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      locked   <= 1'b0;
      busy     <= 1'b0;
      mode     <= 1'b0;
      target   <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      locked   <= locked_nxt;
      busy     <= busy_nxt;
      mode     <= mode_nxt;
      target   <= target_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    locked_nxt   = locked;
    busy_nxt     = busy;
    mode_nxt     = mode;
    target_nxt   = target;
    case (state)
      ST_LOCKING: begin
        if (lock_cnt == LOCK_LAST) begin
          locked_nxt   = 1'b1;
          busy_nxt     = 1'b0;
          lock_cnt_nxt = '0;
          state_nxt    = ST_RUN;
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (eightmhz_s != mode) begin
          locked_nxt  = 1'b0;
          busy_nxt    = 1'b1;
          shreg_nxt   = eightmhz_s ? PROFILE_8M : PROFILE_STD;
          target_nxt  = eightmhz_s;
          bit_cnt_nxt = '0;
          state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_nxt = {shreg[CFG_BITS-2:0], 1'b0};
        if (bit_cnt == BIT_LAST) begin
          state_nxt = ST_UPDATE;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      ST_UPDATE: begin
        mode_nxt  = target;
        state_nxt = ST_LOCKING;
      end
      default: state_nxt = ST_LOCKING;
    endcase
  end

  // Scan outputs decode straight from state so reset removes them asynchronously
  assign scanclkena   = (state == ST_SHIFT);
  assign scandata     = (state == ST_SHIFT) & shreg[CFG_BITS-1];
  assign configupdate = (state == ST_UPDATE);

  // Divider holds at 0 through the first locked cycle, placing the first ena28 four cycles after lock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_p1 <= 1'b0;
      divider   <= 4'd0;
    end else begin
      locked_p1 <= locked;
      if (locked && locked_p1) begin
        divider <= divider + 4'd1;
      end else begin
        divider <= 4'd0;
      end
    end
  end

  assign ena28 = locked & (divider[1:0] == 2'b11);
  assign ena7  = locked & (divider == 4'hF);

`ifdef PLLW_RECONFIG_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reconfig_count <= 8'd0;
    end else if ((state == ST_UPDATE) && (reconfig_count != 8'hFF)) begin
      reconfig_count <= reconfig_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_wrapper_ctrl.sv
// Randomized self-checking bench for pll_wrapper_ctrl against a transaction-level model.
module tb_pll_wrapper_ctrl;

  localparam int LOCK_CYCLES = 64;
  localparam int CFG_BITS    = 16;
  localparam logic [15:0] PROFILE_STD = 16'hA5C3;
  localparam logic [15:0] PROFILE_8M  = 16'h3C5A;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic eightmhz = 1'b0;
  logic locked, ena28, ena7, scanclkena, scandata, configupdate, busy, mode;
`ifdef PLLW_RECONFIG_COUNT_EN
  logic [7:0] reconfig_count;
`endif

  pll_wrapper_ctrl #(
    .LOCK_CYCLES(LOCK_CYCLES),
    .CFG_BITS(CFG_BITS),
    .PROFILE_STD(PROFILE_STD),
    .PROFILE_8M(PROFILE_8M)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .eightmhz(eightmhz),
    .locked(locked),
    .ena28(ena28),
    .ena7(ena7),
    .scanclkena(scanclkena),
    .scandata(scandata),
    .configupdate(configupdate),
    .busy(busy),
    .mode(mode)
`ifdef PLLW_RECONFIG_COUNT_EN
    ,
    .reconfig_count(reconfig_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model state
  logic        model_mode = 1'b0;
  int          exp_pulses = 0;
  int          exp_rc     = 0;
  logic [15:0] exp_word   = 16'h0;

  // Monitor state
  int          lock_age    = 0;
  logic        prev_locked = 1'b0;
  logic [15:0] got_word    = 16'h0;
  int          nbits       = 0;
  int          pulses      = 0;

  // Enables follow from how long locked has been high; scan bits are collected MSB first
  always @(negedge clk) begin
    if (!reset_n) begin
      nbits       = 0;
      prev_locked = 1'b0;
      lock_age    = 0;
    end else begin
      if (locked) lock_age = prev_locked ? lock_age + 1 : 0;
      prev_locked = locked;
      check_val("ena28", ena28, locked && lock_age >= 4 && (lock_age % 4) == 0);
      check_val("ena7", ena7, locked && lock_age >= 16 && (lock_age % 16) == 0);
      if (scanclkena) begin
        got_word = {got_word[14:0], scandata};
        nbits++;
      end
      if (configupdate) begin
        check_val("scan_len", nbits, CFG_BITS);
        check_val("scan_word", got_word, exp_word);
        check_val("cu_no_scan", scanclkena, 0);
        nbits = 0;
        pulses++;
      end
    end
  end

  task automatic wait_lock(input string tag, input int exp_n, input logic exp_busy_before);
    int n;
    logic busy_before;
    n = 0;
    busy_before = busy;
    do begin
      busy_before = busy;
      @(negedge clk);
      n++;
    end while (!locked && n < 400);
    check_val(tag, n, exp_n);
    check_val({tag, "_busy_before"}, busy_before, exp_busy_before);
    check_val({tag, "_busy_clr"}, busy, 0);
  endtask

  task automatic reconfig(input logic req, input bit glitch, input bit first);
    int n;
    exp_word = req ? PROFILE_8M : PROFILE_STD;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 20);
    // Two synchronizer flops plus the RUN compare, or immediate on RUN re-entry
    check_val(first ? "busy_lat" : "busy_lat_rerun", n, first ? 3 : 1);
    check_val("lock_drop", locked, 0);
    if (glitch) begin
      repeat ($urandom_range(1, 10)) @(negedge clk);
      eightmhz = ~req;
    end
    n = 0;
    while (!configupdate && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("cu_seen", configupdate, 1);
    check_val("mode_pre", mode, model_mode);
    exp_pulses++;
    if (exp_rc < 255) exp_rc++;
    @(negedge clk);
    check_val("mode_post", mode, req);
    check_val("cu_single", configupdate, 0);
    model_mode = req;
    // Lock returns LOCK_CYCLES cycles after the configupdate cycle ends
    wait_lock("relock", LOCK_CYCLES, 1);
  endtask

  task automatic episode(input logic req, input bit glitch);
    repeat ($urandom_range(0, 20)) @(negedge clk);
    eightmhz = req;
    if (req == model_mode) begin
      repeat (8) @(negedge clk);
      check_val("idle_busy", busy, 0);
      check_val("idle_locked", locked, 1);
      check_val("idle_mode", mode, model_mode);
    end else begin
      reconfig(req, glitch, 1);
      if (eightmhz != model_mode) reconfig(eightmhz, 0, 0);
    end
    check_val("pulse_count", pulses, exp_pulses);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    #1;
    check_val("rst_locked", locked, 0);
    check_val("rst_ena28", ena28, 0);
    check_val("rst_ena7", ena7, 0);
    check_val("rst_scanclkena", scanclkena, 0);
    check_val("rst_scandata", scandata, 0);
    check_val("rst_configupdate", configupdate, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_mode", mode, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_lock("lock_from_reset", LOCK_CYCLES, 0);
    check_val("reset_mode", mode, 0);
    check_val("reset_no_pulse", pulses, 0);
    check_val("reset_no_scan", nbits, 0);

    episode(1'b1, 0);
    episode(1'b0, 0);
    // Toggle back during SHIFT: one reconfig to 8M, then one back to STD
    p0 = pulses;
    episode(1'b1, 1);
    check_val("glitch_pulses", pulses - p0, 2);
    check_val("glitch_mode", mode, 0);

    for (int i = 0; i < 8; i++) begin
      episode(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    // Abort a STD reconfig at bit 7 of the scan
    if (model_mode == 1'b0) episode(1'b1, 0);
    repeat (4) @(negedge clk);
    eightmhz = 1'b0;
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      if (scanclkena) n++;
      if (!scanclkena && busy && n > 0) break;
    end
    check_val("abort_bitpos", n, 8);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("abort_scanclkena", scanclkena, 0);
    check_val("abort_configupdate", configupdate, 0);
    check_val("abort_scandata", scandata, 0);
    check_val("abort_mode", mode, 0);
    check_val("abort_locked", locked, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_ena28", ena28, 0);
    check_val("abort_ena7", ena7, 0);
    model_mode = 1'b0;
    exp_rc = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_lock("lock_after_abort", LOCK_CYCLES, 0);
    check_val("abort_mode_after", mode, 0);
    repeat (20) @(negedge clk);
    check_val("final_pulses", pulses, exp_pulses);
`ifdef PLLW_RECONFIG_COUNT_EN
    check_val("reconfig_count", reconfig_count, exp_rc);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
